// File: rtl/spi_master_mc_pkg.sv
// Shared definitions for the multi-slave SPI master: FSM state encodings and
// default parameter values.
package spi_master_mc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } spi_state_t;

    localparam int DEF_D_WIDTH = 8;
    localparam int DEF_SLAVES  = 4;
    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DIV_W   = 10;

endpackage

// File: rtl/spi_clk_tick.sv
// SCLK half-period timer: down-counter that pulses tick for one cycle every
// n cycles, with n captured on load.
module spi_clk_tick #(
    parameter int DIV_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] n,
    output logic             tick
);

    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period <= DIV_W'(1);
            cnt    <= '0;
        end else if (load) begin
            period <= n;
            cnt    <= n - DIV_W'(1);
        end else if (cnt == '0) begin
            cnt <= period - DIV_W'(1);
        end else begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/spi_master_mc.sv
// Parametrised multi-slave SPI master with per-transaction mode latch and
// gapless bursts. Optional SPI_LOOPBACK_EN adds a loopback port (rx from mosi).
//
// state | meaning
// IDLE  | sclk tracks cpol, chip selects released, waiting for enable
// RUN   | shifting; 2*D_WIDTH sclk toggles per word
// HOLD  | final half-period with chip select still asserted
module spi_master_mc
    import spi_master_mc_pkg::*;
#(
    parameter int D_WIDTH = DEF_D_WIDTH,
    parameter int SLAVES  = DEF_SLAVES,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DIV_W   = DEF_DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic               lsb_first,
    input  logic               cont,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic [D_WIDTH-1:0] tx_data,
    input  logic               miso,
`ifdef SPI_LOOPBACK_EN
    input  logic               loopback,
`endif
    output logic               sclk,
    output logic [SLAVES-1:0]  ss_n,
    output logic               mosi,
    output logic               busy,
    output logic [D_WIDTH-1:0] rx_data,
    output logic               rx_valid
);

    localparam int CNT_W = $clog2(2 * D_WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * D_WIDTH);

    spi_state_t state, state_next;

    logic               cpha_l, lsb_l;
    logic [D_WIDTH-1:0] tx_sr, rx_sr, rx_next;
    logic [CNT_W-1:0]   edge_cnt, edge_nxt;
    logic [DIV_W-1:0]   div_eff;
    logic               tick, start, lead, last;
    logic               do_sample, do_shift, word_end, rx_src;

    function automatic logic first_bit(input logic [D_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[D_WIDTH-1];
    endfunction

    function automatic logic [D_WIDTH-1:0] shift_word(input logic [D_WIDTH-1:0] w,
                                                      input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    assign div_eff = (clk_div == '0) ? DIV_W'(1) : clk_div;

`ifdef SPI_LOOPBACK_EN
    assign rx_src = loopback ? mosi : miso;
`else
    assign rx_src = miso;
`endif

    assign rx_next = lsb_l ? {rx_src, rx_sr[D_WIDTH-1:1]} : {rx_sr[D_WIDTH-2:0], rx_src};

    spi_clk_tick #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .load (start),
        .n    (div_eff),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        do_sample  = 1'b0;
        do_shift   = 1'b0;
        word_end   = 1'b0;
        edge_nxt   = edge_cnt + CNT_W'(1);
        lead       = edge_nxt[0];
        last       = (edge_nxt == LAST_EDGE);
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (tick) begin
                    // cpha selects which edge parity samples; the other one shifts
                    do_sample = lead ^ cpha_l;
                    do_shift  = ~(lead ^ cpha_l) & ~last;
                    word_end  = last;
                    if (last && !cont) state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk     <= 1'b0;
            ss_n     <= '1;
            mosi     <= 1'b1;
            busy     <= 1'b0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            edge_cnt <= '0;
            cpha_l   <= 1'b0;
            lsb_l    <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (start) begin
                cpha_l   <= cpha;
                lsb_l    <= lsb_first;
                sclk     <= cpol;
                busy     <= 1'b1;
                edge_cnt <= '0;
                for (int i = 0; i < SLAVES; i++) ss_n[i] <= (addr != ADDR_W'(i));
                if (!cpha) begin
                    mosi  <= first_bit(tx_data, lsb_first);
                    tx_sr <= shift_word(tx_data, lsb_first);
                end else begin
                    tx_sr <= tx_data;
                end
            end else if (state == ST_IDLE) begin
                sclk <= cpol;
                ss_n <= '1;
                mosi <= 1'b1;
                busy <= 1'b0;
            end else if (state == ST_RUN && tick) begin
                sclk     <= ~sclk;
                edge_cnt <= last ? '0 : edge_nxt;
                if (do_sample) rx_sr <= rx_next;
                if (do_shift) begin
                    mosi  <= first_bit(tx_sr, lsb_l);
                    tx_sr <= shift_word(tx_sr, lsb_l);
                end
                if (word_end && cont) begin
                    // burst continuation: report this word, load the next without a gap
                    rx_data  <= do_sample ? rx_next : rx_sr;
                    rx_valid <= 1'b1;
                    if (!cpha_l) begin
                        mosi  <= first_bit(tx_data, lsb_l);
                        tx_sr <= shift_word(tx_data, lsb_l);
                    end else begin
                        tx_sr <= tx_data;
                    end
                end
            end else if (state == ST_HOLD && tick) begin
                ss_n     <= '1;
                mosi     <= 1'b1;
                busy     <= 1'b0;
                rx_data  <= rx_sr;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_mc.sv
// Directed bench for spi_master_mc: table of single-word transfers plus
// burst, mid-transfer reset, ignored-input and back-to-back sequences.
module tb_spi_master_mc;

    logic       clk = 1'b0, rst = 1'b0, enable = 1'b0;
    logic       cpol = 1'b0, cpha = 1'b0, lsb_first = 1'b0, cont = 1'b0;
    logic [1:0] addr = 2'd0;
    logic [9:0] clk_div = 10'd0;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       miso, sclk, mosi, busy, rx_valid;
    logic [3:0] ss_n;
    logic       loop_en = 1'b0, miso_s = 1'b1;

    int total = 0, passed = 0, cyc = 0;

    assign miso = loop_en ? mosi : miso_s;

    spi_master_mc dut (
        .clk(clk), .rst(rst), .enable(enable), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cont(cont), .addr(addr), .clk_div(clk_div),
        .tx_data(tx_data), .miso(miso),
`ifdef SPI_LOOPBACK_EN
        .loopback(1'b0),
`endif
        .sclk(sclk), .ss_n(ss_n), .mosi(mosi), .busy(busy),
        .rx_data(rx_data), .rx_valid(rx_valid)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic       cpol, cpha, lsb, loop;
        logic [1:0] addr;
        logic [9:0] div;
        logic [7:0] tx, srx, exp_rx, exp_mosi;
        logic [3:0] ss;
        int         cyc;
        int         n;
    } vec_t;

    vec_t vecs[6];

    // Slave model and bus monitor, evaluated on the falling edge.
    int         edges = 0, min_sp = 0, max_sp = 0, last_edge = 0;
    logic [31:0] mosi_bits = 0;
    logic       ss_glitch = 1'b0, prev_sclk = 1'b0;
    logic [3:0] prev_ss = 4'hF;
    logic [7:0] slave_words[3];

    function automatic logic sbit(input logic [7:0] w, input int idx, input logic lsb);
        return lsb ? w[idx] : w[7-idx];
    endfunction

    initial forever begin
        int  w, idx, sp;
        bit  lead;
        @(negedge clk);
        if (prev_ss == 4'hF && ss_n != 4'hF) begin
            edges = 0; mosi_bits = 0; min_sp = 1000000; max_sp = 0;
            last_edge = 0; ss_glitch = 1'b0;
            if (!cpha) miso_s = sbit(slave_words[0], 0, lsb_first);
        end
        if (busy && ss_n == 4'hF) ss_glitch = 1'b1;
        if (busy && sclk !== prev_sclk) begin
            edges++;
            if (last_edge != 0) begin
                sp = cyc - last_edge;
                if (sp < min_sp) min_sp = sp;
                if (sp > max_sp) max_sp = sp;
            end
            last_edge = cyc;
            lead = (edges % 2 == 1);
            if (lead != cpha) mosi_bits = {mosi_bits[30:0], mosi};
            w = -1; idx = 0;
            if (!cpha && !lead) begin
                w = edges / 16; idx = (edges / 2) % 8;
            end else if (cpha && lead) begin
                w = (edges - 1) / 16; idx = ((edges - 1) / 2) % 8;
            end
            if (w >= 0 && w < 3) miso_s = sbit(slave_words[w], idx, lsb_first);
        end
        prev_sclk = sclk;
        prev_ss   = ss_n;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic apply_cfg(input vec_t v);
        cpol = v.cpol; cpha = v.cpha; lsb_first = v.lsb; loop_en = v.loop;
        addr = v.addr; clk_div = v.div; tx_data = v.tx; cont = 1'b0;
        slave_words[0] = v.srx;
    endtask

    task automatic do_xfer(input vec_t v, input bit disturb);
        int rel, start_cyc, done;
        @(negedge clk);
        apply_cfg(v);
        repeat (2) @(negedge clk);
        chk("sclk_idle", sclk, v.cpol);
        #1 enable = 1'b1;
        start_cyc = cyc;
        done = 0;
        for (int k = 0; k < 3000 && done == 0; k++) begin
            @(posedge clk); #1;
            rel = cyc - start_cyc;
            if (rel == 1) begin
                if (!disturb) enable = 1'b0;
                chk("ss_active", ss_n, v.ss);
                chk("busy_run", busy, 1'b1);
            end
            if (disturb) begin
                if (rel >= 2 && rel < 40) enable = (rel % 2 == 1);
                if (rel == 40) enable = 1'b0;
                if (rel == 20) begin
                    cpol = ~v.cpol; clk_div = 10'd9; tx_data = 8'hFF;
                end
            end
            if (rx_valid) done = rel;
        end
        enable = 1'b0;
        if (done == 0) begin
            chk("xfer_timeout", 32'd0, 32'd1);
        end else begin
            chk("done_cycle", done, v.cyc);
            chk("rx_data", rx_data, v.exp_rx);
            chk("busy_done", busy, 1'b0);
            chk("ss_released", ss_n, 4'hF);
            chk("mosi_idle", mosi, 1'b1);
            chk("sclk_end", sclk, v.cpol);
        end
        cpol = v.cpol; clk_div = v.div; tx_data = v.tx;
        @(posedge clk); #1;
        chk("rx_valid_one_cycle", rx_valid, 1'b0);
        chk("sclk_edges", edges, 16);
        chk("mosi_stream", mosi_bits[7:0], v.exp_mosi);
        chk("spacing_min", min_sp, v.n);
        chk("spacing_max", max_sp, v.n);
    endtask

    initial begin
        int        rel, start_cyc, pulses;
        int        pcyc[3];
        logic [7:0] prx[3];
        logic      pbusy[3];
        logic      saw_v;
        bit        got;

        //            cpol cpha lsb  loop addr  div     tx     srx    exp_rx exp_mosi ss       cyc n
        vecs[0] = '{1'b0,1'b0,1'b0,1'b0,2'd2,10'd4,8'hA5,8'h3C,8'h3C,8'hA5,4'b1011,69,4};
        vecs[1] = '{1'b0,1'b1,1'b0,1'b1,2'd1,10'd0,8'h81,8'h00,8'h81,8'h81,4'b1101,18,1};
        vecs[2] = '{1'b1,1'b0,1'b0,1'b1,2'd0,10'd0,8'h81,8'h00,8'h81,8'h81,4'b1110,18,1};
        vecs[3] = '{1'b1,1'b1,1'b0,1'b1,2'd3,10'd0,8'h81,8'h00,8'h81,8'h81,4'b0111,18,1};
        vecs[4] = '{1'b0,1'b0,1'b1,1'b0,2'd1,10'd2,8'h01,8'h80,8'h80,8'h80,4'b1101,35,2};
        vecs[5] = '{1'b1,1'b1,1'b0,1'b0,2'd0,10'd3,8'h5A,8'hC3,8'hC3,8'h5A,4'b1110,52,3};
        slave_words[0] = 8'h00; slave_words[1] = 8'h00; slave_words[2] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_ss_n", ss_n, 4'hF);
        chk("rst_mosi", mosi, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_rx_valid", rx_valid, 1'b0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) do_xfer(vecs[i], 1'b0);

        // Three-word burst, mode 0, N=2
        @(negedge clk);
        cpol = 0; cpha = 0; lsb_first = 0; loop_en = 0; addr = 2'd1; clk_div = 10'd2;
        tx_data = 8'h11; cont = 1'b1;
        slave_words[0] = 8'hC1; slave_words[1] = 8'hC2; slave_words[2] = 8'hC3;
        for (int i = 0; i < 3; i++) begin pcyc[i] = 0; prx[i] = 8'h00; pbusy[i] = 1'b0; end
        repeat (2) @(negedge clk);
        #1 enable = 1'b1;
        start_cyc = cyc;
        pulses = 0;
        for (int k = 0; k < 3000 && pulses < 3; k++) begin
            @(posedge clk); #1;
            rel = cyc - start_cyc;
            if (rel == 1) begin enable = 1'b0; tx_data = 8'h22; end
            if (rx_valid) begin
                pcyc[pulses] = rel; prx[pulses] = rx_data; pbusy[pulses] = busy;
                pulses++;
                if (pulses == 1) tx_data = 8'h33;
                if (pulses == 2) cont = 1'b0;
            end
        end
        if (pulses < 3) chk("burst_timeout", 32'd0, 32'd1);
        chk("burst_rx0", prx[0], 8'hC1);
        chk("burst_rx1", prx[1], 8'hC2);
        chk("burst_rx2", prx[2], 8'hC3);
        chk("burst_cyc0", pcyc[0], 33);
        chk("burst_cyc1", pcyc[1], 65);
        chk("burst_cyc2", pcyc[2], 99);
        chk("burst_busy0", pbusy[0], 1'b1);
        chk("burst_busy1", pbusy[1], 1'b1);
        chk("burst_busy2", pbusy[2], 1'b0);
        chk("burst_edges", edges, 48);
        chk("burst_spacing_min", min_sp, 2);
        chk("burst_spacing_max", max_sp, 2);
        chk("burst_ss_held", ss_glitch, 1'b0);
        chk("burst_mosi", mosi_bits[23:0], 24'h112233);

        // Asynchronous reset at cycle 30 of a transfer
        @(negedge clk);
        apply_cfg(vecs[0]);
        repeat (2) @(negedge clk);
        #1 enable = 1'b1;
        start_cyc = cyc;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            rel = cyc - start_cyc;
            if (rel == 1) enable = 1'b0;
            if (rel == 30) got = 1'b1;
        end
        rst = 1'b0;
        #1;
        chk("abort_sclk", sclk, 1'b0);
        chk("abort_ss_n", ss_n, 4'hF);
        chk("abort_mosi", mosi, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_rx_data", rx_data, 8'h00);
        saw_v = rx_valid;
        repeat (5) begin
            @(posedge clk); #1;
            saw_v = saw_v | rx_valid;
        end
        chk("abort_no_rx_valid", saw_v, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        do_xfer(vecs[0], 1'b0);

        // enable pulses, cpol/clk_div/tx_data changes while busy are ignored
        do_xfer(vecs[0], 1'b1);

        // Back-to-back with enable held high
        @(negedge clk);
        apply_cfg(vecs[0]);
        repeat (2) @(negedge clk);
        #1 enable = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            if (rx_valid) got = 1'b1;
        end
        if (!got) chk("b2b_timeout", 32'd0, 32'd1);
        chk("b2b_busy_low", busy, 1'b0);
        @(posedge clk); #1;
        chk("b2b_restart", busy, 1'b1);
        chk("b2b_ss", ss_n, 4'b1011);
        enable = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            if (rx_valid) got = 1'b1;
        end
        if (!got) chk("b2b_timeout2", 32'd0, 32'd1);
        chk("b2b_rx_data", rx_data, 8'h3C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
